// File: rtl/mod_inverse_gen_if.sv
// Request/result bundle for the modular-inverse engine.
//
// Handshake: the master holds `start` high with `e`/`totient` stable; the
// engine accepts on the first rising edge where it is idle (busy low), latching
// the operands, and raises `busy` from the next cycle. Completion is a single
// `done` pulse; `valid`/`d` are updated at that same edge and hold until the
// next acceptance. `start` seen while busy is dropped, not queued.
interface mod_inverse_gen_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] totient;
  logic             busy;
  logic             done;
  logic             valid;
  logic [WIDTH-1:0] d;
  // Engine FSM state: 0 IDLE, 1 DIV, 2 UPDATE, 3 FIX.
  logic [1:0]       dbg_state;

  modport master (
    output start, e, totient,
    input  busy, done, valid, d, dbg_state
  );

  modport slave (
    input  start, e, totient,
    output busy, done, valid, d, dbg_state
  );
endinterface

// File: rtl/mod_inverse_gen.sv
// Modular-inverse engine: iterative extended Euclid (t-coefficients only),
// with each quotient produced by a WIDTH-cycle bit-serial restoring divider.
// Result d satisfies (e*d) mod totient = 1 when valid is high.
module mod_inverse_gen #(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst,
  mod_inverse_gen_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIV    = 2'd1,
    S_UPDATE = 2'd2,
    S_FIX    = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] tot_q,    tot_d;
  logic [WIDTH-1:0] old_r_q,  old_r_d;
  logic [WIDTH-1:0] r_q,      r_d;
  logic [WIDTH:0]   old_t_q,  old_t_d;
  logic [WIDTH:0]   t_q,      t_d;
  // Divider: partial remainder and the dividend/quotient shift register.
  logic [WIDTH-1:0] rem_q,    rem_d;
  logic [WIDTH-1:0] quo_q,    quo_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] res_q,    res_d;

  // One restoring-division step: shift in the next dividend bit, subtract the
  // divisor if it fits. The partial remainder stays below r, so WIDTH bits hold it.
  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH:0]   rem_sub;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, r_q});
    rem_sub   = rem_shift - {1'b0, r_q};
    rem_step  = fits ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], fits};
  end

  // Coefficient update old_t - q*t, taken modulo 2^(WIDTH+1); the true value
  // always fits in that two's-complement range, so the wrap is exact.
  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] qt_prod;
  logic [WIDTH:0] t_next;

  always_comb begin
    q_ext   = {1'b0, quo_q};
    qt_prod = q_ext * t_q;
    t_next  = old_t_q - qt_prod;
  end

  // Final result: no inverse unless gcd is 1 and the modulus is meaningful;
  // a negative coefficient is brought into [0, totient) by adding totient once.
  logic             no_inv;
  logic [WIDTH-1:0] d_fix;

  always_comb begin
    no_inv = (tot_q < WIDTH'(2)) || (old_r_q != WIDTH'(1));
    d_fix  = old_t_q[WIDTH] ? (old_t_q[WIDTH-1:0] + tot_q) : old_t_q[WIDTH-1:0];
  end

  // Next-state logic for the controller and the datapath registers.
  always_comb begin
    state_d = state_q;
    tot_d   = tot_q;
    old_r_d = old_r_q;
    r_d     = r_q;
    old_t_d = old_t_q;
    t_d     = t_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tot_d   = bus.totient;
          old_r_d = bus.totient;
          r_d     = bus.e;
          old_t_d = '0;
          t_d     = (WIDTH+1)'(1);
          // Prime the divider with old_r as dividend.
          rem_d   = '0;
          quo_d   = bus.totient;
          cnt_d   = '0;
          valid_d = 1'b0;
          res_d   = '0;
          busy_d  = 1'b1;
          if ((bus.totient < WIDTH'(2)) || (bus.e == '0)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_DIV;
          end
        end
      end

      S_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        old_r_d = r_q;
        r_d     = rem_q;
        old_t_d = t_q;
        t_d     = t_next;
        // Next division is old_r (= current r) by the fresh remainder.
        quo_d   = r_q;
        rem_d   = '0;
        cnt_d   = '0;
        if (rem_q == '0) begin
          state_d = S_FIX;
        end else begin
          state_d = S_DIV;
        end
      end

      S_FIX: begin
        if (no_inv) begin
          valid_d = 1'b0;
          res_d   = '0;
        end else begin
          valid_d = 1'b1;
          res_d   = d_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tot_q   <= '0;
      old_r_q <= '0;
      r_q     <= '0;
      old_t_q <= '0;
      t_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
      old_r_q <= old_r_d;
      r_q     <= r_d;
      old_t_q <= old_t_d;
      t_q     <= t_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  // Registered outputs straight from flops.
  always_comb begin
    bus.busy      = busy_q;
    bus.done      = done_q;
    bus.valid     = valid_q;
    bus.d         = res_q;
    bus.dbg_state = state_q;
  end

endmodule

// File: tb/tb_mod_inverse_gen.sv
// Directed bench for mod_inverse_gen (WIDTH=12): hand-computed Euclid runs,
// degenerate inputs, start/reset hazards and back-to-back acceptance.
module tb_mod_inverse_gen;

  localparam int W = 12;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  mod_inverse_gen_if #(.WIDTH(W)) bus ();

  mod_inverse_gen #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Accept one request at edge 0 and wait for done, which must appear after
  // edge n_it*(W+1)+1. A nonzero repulse_edge re-raises start (with e=7)
  // just before that edge while the engine is busy.
  task automatic run_op(input string tag, input logic [W-1:0] tot, input logic [W-1:0] ev,
                        input int n_it, input logic exp_valid, input logic [W-1:0] exp_d,
                        input int repulse_edge);
    int k;
    int exp_k;
    int limit;
    int busy_bad;
    bit seen;
    bus.totient = tot;
    bus.e       = ev;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    check({tag, "_done_low_after_accept"}, 32'(bus.done), 32'd0);
    check({tag, "_valid_cleared"}, 32'(bus.valid), 32'd0);
    exp_k    = n_it * (W + 1) + 1;
    limit    = exp_k + 20;
    k        = 0;
    seen     = 1'b0;
    busy_bad = 0;
    while (!seen && k < limit) begin
      if (repulse_edge != 0 && k + 1 == repulse_edge) begin
        bus.start = 1'b1;
        bus.e     = 12'd7;
      end
      tick();
      k++;
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) busy_bad++;
    end
    if (!seen) k = limit + 1;
    check({tag, "_done_edge"}, 32'(k), 32'(exp_k));
    check({tag, "_busy_gaps"}, 32'(busy_bad), 32'd0);
    check({tag, "_busy_low_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_valid"}, 32'(bus.valid), 32'(exp_valid));
    check({tag, "_d"}, 32'(bus.d), 32'(exp_d));
  endtask

  // Directed sequence
  initial begin
    int seen_done;
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.e     = '0;
    bus.totient = '0;
    repeat (3) tick();
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_d",     32'(bus.d),     32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // 20/3: q = 6,1,2 -> d=7
    run_op("t20_e3", 12'd20, 12'd3, 3, 1'b1, 12'd7, 0);
    check("t20_e3_state_idle_at_done", 32'(bus.dbg_state), 32'd0);
    // Back-to-back: start raised during the done cycle -> 20/7, d=3
    run_op("b2b_t20_e7", 12'd20, 12'd7, 3, 1'b1, 12'd3, 0);
    tick();
    check("b2b_done_one_cycle", 32'(bus.done), 32'd0);
    check("b2b_valid_held", 32'(bus.valid), 32'd1);
    check("b2b_d_held", 32'(bus.d), 32'd3);

    // Reset mid-operation at edge 15
    bus.totient = 12'd20;
    bus.e       = 12'd3;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy",  32'(bus.busy),  32'd0);
    check("midrst_done",  32'(bus.done),  32'd0);
    check("midrst_valid", 32'(bus.valid), 32'd0);
    check("midrst_d",     32'(bus.d),     32'd0);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.done) seen_done++;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    run_op("after_rst_t20_e3", 12'd20, 12'd3, 3, 1'b1, 12'd7, 0);

    // e > totient: first quotient 0 swaps operands
    tick();
    run_op("t20_e23", 12'd20, 12'd23, 5, 1'b1, 12'd7, 0);
    // Large quotient (2047) and negative fix-up: -2047 + 4095 = 2048
    tick();
    run_op("t4095_e2", 12'd4095, 12'd2, 2, 1'b1, 12'd2048, 0);
    // gcd 4: no inverse
    tick();
    run_op("t20_e4", 12'd20, 12'd4, 1, 1'b0, 12'd0, 0);
    // Degenerate early exits
    run_op("t1_e0", 12'd1, 12'd0, 0, 1'b0, 12'd0, 0);
    run_op("t20_e0", 12'd20, 12'd0, 0, 1'b0, 12'd0, 0);
    // start re-pulsed with e=7 at edge 10: ignored, result still d=7
    tick();
    run_op("repulse_t20_e3", 12'd20, 12'd3, 3, 1'b1, 12'd7, 10);
    repeat (3) tick();
    check("repulse_no_second_start", 32'(bus.busy), 32'd0);
    check("repulse_d_held", 32'(bus.d), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
